// File: rtl/adc128s022_emulator.sv
// adc128s022_emulator
//   Slave-side model of the ADC128S022 serial interface. It answers the controller's chip
//   select, serial clock and channel-address line, and shifts 12-bit values taken from eight
//   parallel channel inputs out on dout. All serial pins are oversampled in the clk_50M domain.
//
// Ports
//   clk_50M    : system clock
//   rst_n      : synchronous active-low reset
//   adc_sck    : serial clock from the controller (asynchronous)
//   adc_cs_n   : chip select, active low (asynchronous)
//   din        : serial channel address, ADD2..ADD0 on rising edges 3..5 (asynchronous)
//   dout       : serial conversion data, 4 zeros then D11..D0, changes after sck falls
//   ch_values  : eight 12-bit channel values, channel n at [12n+11:12n]
//   conv_ch    : channel currently being shifted out
//   frame_done : one-cycle pulse per completed 16-bit frame
//   last_addr  : address captured in the last completed frame
module adc128s022_emulator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_CH    = 0
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        adc_sck,
  input  logic        adc_cs_n,
  input  logic        din,
  output logic        dout,
  input  logic [95:0] ch_values,
  output logic [2:0]  conv_ch,
  output logic        frame_done,
  output logic [2:0]  last_addr
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  localparam logic [2:0] ResetCh = RESET_CH[2:0];

  // Synchronizers plus one history flop each for edge detection. sck and cs_n reset to
  // their idle-high level so leaving reset with the bus idle creates no spurious strobe.
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, din_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      sck_sync_q <= '1;
      cs_sync_q  <= '1;
      din_sync_q <= '0;
      sck_prev_q <= 1'b1;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], adc_sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, din_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // Frame state
  logic [0:0]  state_q, state_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [2:0]  addr_sr_q, addr_sr_d;
  logic [2:0]  next_ch_q, next_ch_d;
  logic [2:0]  last_addr_q, last_addr_d;
  logic [2:0]  conv_ch_q, conv_ch_d;
  logic        frame_done_q, frame_done_d;
  logic        dout_q, dout_d;
  logic [11:0] load_val;

  // Value of the channel that the next load will convert.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < 8; i++) begin
      if (next_ch_q == 3'(i)) load_val = ch_values[12*i +: 12];
    end
  end

  always_comb begin
    state_d      = state_q;
    rise_cnt_d   = rise_cnt_q;
    shreg_d      = shreg_q;
    addr_sr_d    = addr_sr_q;
    next_ch_d    = next_ch_q;
    last_addr_d  = last_addr_q;
    conv_ch_d    = conv_ch_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // sck strobes coinciding with cs_fall are dropped
        if (cs_fall) begin
          shreg_d    = {4'b0000, load_val};
          conv_ch_d  = next_ch_q;
          rise_cnt_d = '0;
          state_d    = StActive;
        end
      end
      StActive: begin
        if (cs_rise) begin
          // Abort or normal end; next_ch is only updated by a completed frame
          state_d = StIdle;
        end else if (sck_rise) begin
          if (rise_cnt_q == 5'd16) begin
            // Rising edge without the reload fall: reload now and count it as rise 1
            shreg_d    = {4'b0000, load_val};
            conv_ch_d  = next_ch_q;
            rise_cnt_d = 5'd1;
          end else begin
            rise_cnt_d = rise_cnt_q + 5'd1;
            if (rise_cnt_q == 5'd2 || rise_cnt_q == 5'd3 || rise_cnt_q == 5'd4) begin
              addr_sr_d = {addr_sr_q[1:0], din_s};
            end
            if (rise_cnt_q == 5'd15) begin
              next_ch_d    = addr_sr_q;
              last_addr_d  = addr_sr_q;
              frame_done_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (rise_cnt_q == 5'd16) begin
            // Continuous mode: cs still low, start the next frame
            shreg_d    = {4'b0000, load_val};
            conv_ch_d  = next_ch_q;
            rise_cnt_d = '0;
          end else if (rise_cnt_q != 5'd0) begin
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered from next-state so dout moves one cycle after the sck_fall strobe.
    dout_d = (state_d == StActive) ? shreg_d[15] : 1'b0;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rise_cnt_q   <= '0;
      shreg_q      <= '0;
      addr_sr_q    <= '0;
      next_ch_q    <= ResetCh;
      last_addr_q  <= '0;
      conv_ch_q    <= ResetCh;
      frame_done_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rise_cnt_q   <= rise_cnt_d;
      shreg_q      <= shreg_d;
      addr_sr_q    <= addr_sr_d;
      next_ch_q    <= next_ch_d;
      last_addr_q  <= last_addr_d;
      conv_ch_q    <= conv_ch_d;
      frame_done_q <= frame_done_d;
      dout_q       <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign conv_ch    = conv_ch_q;
  assign frame_done = frame_done_q;
  assign last_addr  = last_addr_q;

endmodule

// File: tb/tb_adc128s022_emulator.sv
// Directed bench for adc128s022_emulator: bit-bangs the controller side at 3.125 MHz
// (8 clk_50M cycles per sck half period) and compares captured frames against hand values.
module tb_adc128s022_emulator;

  localparam int HALF = 8;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        adc_sck = 1'b1;
  logic        adc_cs_n = 1'b1;
  logic        din     = 1'b0;
  logic        dout;
  logic [95:0] ch_values;
  logic [2:0]  conv_ch;
  logic        frame_done;
  logic [2:0]  last_addr;

  logic [11:0] chv [8];

  int tests = 0;
  int fails = 0;
  int fd_total = 0;

  assign ch_values = {chv[7], chv[6], chv[5], chv[4], chv[3], chv[2], chv[1], chv[0]};

  adc128s022_emulator #(
    .SYNC_STAGES(2),
    .RESET_CH   (0)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .adc_sck   (adc_sck),
    .adc_cs_n  (adc_cs_n),
    .din       (din),
    .dout      (dout),
    .ch_values (ch_values),
    .conv_ch   (conv_ch),
    .frame_done(frame_done),
    .last_addr (last_addr)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) if (frame_done === 1'b1) fd_total++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // One controller frame. nrise rising edges are issued; chg_rise sets ch1 to 0xFFF after
  // that rise; rst_rise pulses rst_n for one cycle after that rise and ends the frame.
  task automatic frame(input logic [2:0] addr, input int nrise, input int chg_rise,
                       input int rst_rise, input bit cs_start, input bit cs_end,
                       output logic [15:0] got, output logic [2:0] conv_mid);
    got      = '0;
    conv_mid = '0;
    if (cs_start) begin
      adc_cs_n = 1'b0;
      wait_clk(HALF);
    end
    for (int k = 1; k <= nrise; k++) begin
      adc_sck = 1'b0;
      case (k)
        3:       din = addr[2];
        4:       din = addr[1];
        5:       din = addr[0];
        default: din = 1'b0;
      endcase
      wait_clk(HALF);
      adc_sck = 1'b1;
      got[16-k] = dout;
      if (k == 8) conv_mid = conv_ch;
      if (k == chg_rise) chv[1] = 12'hFFF;
      wait_clk(HALF);
      if (k == rst_rise) begin
        adc_cs_n = 1'b1;
        din      = 1'b0;
        rst_n    = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        return;
      end
    end
    din = 1'b0;
    if (cs_end) begin
      adc_cs_n = 1'b1;
      wait_clk(2 * HALF);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(4);
    tests++;
    if (dout !== 1'b0) begin
      fails++; $display("FAIL reset_dout got %b exp 0", dout);
    end
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL reset_frame_done got %b exp 0", frame_done);
    end
    tests++;
    if (last_addr !== 3'd0) begin
      fails++; $display("FAIL reset_last_addr got %0d exp 0", last_addr);
    end
    tests++;
    if (conv_ch !== 3'd0) begin
      fails++; $display("FAIL reset_conv_ch got %0d exp 0", conv_ch);
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_first_frames();
    logic [15:0] got;
    logic [2:0]  cm;
    int          fd0;
    fd0 = fd_total;
    frame(3'd1, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0000) begin
      fails++; $display("FAIL first_frame_data got %h exp 0000", got);
    end
    tests++;
    if (fd_total - fd0 != 1) begin
      fails++; $display("FAIL first_frame_done got %0d exp 1", fd_total - fd0);
    end
    tests++;
    if (last_addr !== 3'd1) begin
      fails++; $display("FAIL first_last_addr got %0d exp 1", last_addr);
    end
    frame(3'd4, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0A5C) begin
      fails++; $display("FAIL ch1_data got %h exp 0a5c", got);
    end
    tests++;
    if (cm !== 3'd1) begin
      fails++; $display("FAIL ch1_conv_ch got %0d exp 1", cm);
    end
    tests++;
    if (last_addr !== 3'd4) begin
      fails++; $display("FAIL ch1_last_addr got %0d exp 4", last_addr);
    end
    frame(3'd3, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0123) begin
      fails++; $display("FAIL ch4_data got %h exp 0123", got);
    end
    tests++;
    if (cm !== 3'd4) begin
      fails++; $display("FAIL ch4_conv_ch got %0d exp 4", cm);
    end
  endtask

  // 30 frames addressing 1,4,3; each returns the channel addressed one frame earlier.
  task automatic test_rotation();
    logic [2:0]  seq [3];
    logic [15:0] expv [3];
    logic [15:0] got;
    logic [2:0]  cm;
    int          fd0;
    seq[0] = 3'd1; seq[1] = 3'd4; seq[2] = 3'd3;
    // Returned value for frame i, indexed by i%3: prev addr is 3, 1, 4 respectively
    expv[0] = 16'h03C3; expv[1] = 16'h0A5C; expv[2] = 16'h0123;
    fd0 = fd_total;
    for (int i = 0; i < 30; i++) begin
      frame(seq[i%3], 16, 0, 0, 1'b1, 1'b1, got, cm);
      tests++;
      if (got !== expv[i%3]) begin
        fails++; $display("FAIL rotation_%0d got %h exp %h", i, got, expv[i%3]);
      end
    end
    tests++;
    if (fd_total - fd0 != 30) begin
      fails++; $display("FAIL rotation_frame_done got %0d exp 30", fd_total - fd0);
    end
    tests++;
    if (last_addr !== 3'd3) begin
      fails++; $display("FAIL rotation_last_addr got %0d exp 3", last_addr);
    end
  endtask

  task automatic test_value_change();
    logic [15:0] got;
    logic [2:0]  cm;
    frame(3'd1, 16, 0, 0, 1'b1, 1'b1, got, cm);
    frame(3'd1, 16, 6, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0A5C) begin
      fails++; $display("FAIL change_in_flight got %h exp 0a5c", got);
    end
    frame(3'd2, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0FFF) begin
      fails++; $display("FAIL change_next got %h exp 0fff", got);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    logic [2:0]  cm;
    int          fd0;
    fd0 = fd_total;
    frame(3'd7, 8, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (dout !== 1'b0) begin
      fails++; $display("FAIL abort_dout got %b exp 0", dout);
    end
    tests++;
    if (fd_total != fd0) begin
      fails++; $display("FAIL abort_frame_done got %0d exp 0", fd_total - fd0);
    end
    tests++;
    if (last_addr !== 3'd2) begin
      fails++; $display("FAIL abort_last_addr got %0d exp 2", last_addr);
    end
    frame(3'd5, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h02B2) begin
      fails++; $display("FAIL after_abort_data got %h exp 02b2", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got_a, got_b;
    logic [2:0]  cm;
    int          fd0;
    fd0 = fd_total;
    frame(3'd3, 16, 0, 0, 1'b1, 1'b0, got_a, cm);
    frame(3'd6, 16, 0, 0, 1'b0, 1'b1, got_b, cm);
    tests++;
    if (got_a !== 16'h05D5) begin
      fails++; $display("FAIL b2b_first got %h exp 05d5", got_a);
    end
    tests++;
    if (got_b !== 16'h03C3) begin
      fails++; $display("FAIL b2b_second got %h exp 03c3", got_b);
    end
    tests++;
    if (cm !== 3'd3) begin
      fails++; $display("FAIL b2b_conv_ch got %0d exp 3", cm);
    end
    tests++;
    if (fd_total - fd0 != 2) begin
      fails++; $display("FAIL b2b_frame_done got %0d exp 2", fd_total - fd0);
    end
    tests++;
    if (last_addr !== 3'd6) begin
      fails++; $display("FAIL b2b_last_addr got %0d exp 6", last_addr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] got;
    logic [2:0]  cm;
    frame(3'd2, 16, 0, 10, 1'b1, 1'b1, got, cm);
    tests++;
    if (dout !== 1'b0) begin
      fails++; $display("FAIL midreset_dout got %b exp 0", dout);
    end
    tests++;
    if (last_addr !== 3'd0) begin
      fails++; $display("FAIL midreset_last_addr got %0d exp 0", last_addr);
    end
    tests++;
    if (conv_ch !== 3'd0) begin
      fails++; $display("FAIL midreset_conv_ch got %0d exp 0", conv_ch);
    end
    wait_clk(2 * HALF);
    frame(3'd1, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0000) begin
      fails++; $display("FAIL midreset_first got %h exp 0000", got);
    end
    frame(3'd4, 16, 0, 0, 1'b1, 1'b1, got, cm);
    tests++;
    if (got !== 16'h0FFF) begin
      fails++; $display("FAIL midreset_second got %h exp 0fff", got);
    end
    tests++;
    if (last_addr !== 3'd4) begin
      fails++; $display("FAIL midreset_last_addr2 got %0d exp 4", last_addr);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    chv[0] = 12'h000; chv[1] = 12'hA5C; chv[2] = 12'h2B2; chv[3] = 12'h3C3;
    chv[4] = 12'h123; chv[5] = 12'h5D5; chv[6] = 12'h6E6; chv[7] = 12'h7F7;
    test_reset();
    test_first_frames();
    test_rotation();
    test_value_change();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
